// File: rtl/conv_ddr_pkg.sv
// rtl/conv_ddr_pkg.sv - shared port indices, outstanding-entry type and round-robin helpers
package conv_ddr_pkg;

    localparam logic [1:0] PORT_WEIGHTS = 2'd0;
    localparam logic [1:0] PORT_IFMAP   = 2'd1;
    localparam logic [1:0] PORT_BIAS    = 2'd2;

    localparam int OUTST_LEN_W = 16;

    typedef struct packed {
        logic [1:0]             owner;
        logic [OUTST_LEN_W-1:0] length;
    } outst_entry_t;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_BIAS) ? PORT_WEIGHTS : p + 2'd1;
    endfunction

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    // Later assignments win, so the candidate nearest the pointer takes priority.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] c0, c1, c2, pick;
        c0   = ptr;
        c1   = next_port(c0);
        c2   = next_port(c1);
        pick = ptr;
        if (req[c2]) pick = c2;
        if (req[c1]) pick = c1;
        if (req[c0]) pick = c0;
        return pick;
    endfunction

endpackage

// File: rtl/ddr_outst_fifo.sv
// rtl/ddr_outst_fifo.sv - outstanding-command FIFO with count and simultaneous push/pop
module ddr_outst_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_cmd_arbiter.sv
// rtl/ddr_rd_cmd_arbiter.sv - round-robin DDR read-command arbiter with return-beat routing
module ddr_rd_cmd_arbiter
    import conv_ddr_pkg::*;
#(
    parameter int ADR_W       = 32,
    parameter int LEN_W       = 16,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2:0]                     req_valid,
    input  logic [3*ADR_W-1:0]             req_base_adr,
    input  logic [3*LEN_W-1:0]             req_length,
    output logic [2:0]                     req_grant,
    input  logic                           ddr_cmd_ready,
    output logic                           ddr_cmd_valid,
    output logic [ADR_W-1:0]               ddr_cmd_base_adr,
    output logic [LEN_W-1:0]               ddr_cmd_length,
    input  logic                           ddr_rd_data_valid,
    output logic [2:0]                     rd_route_valid,
    output logic                           rd_last,
    output logic [$clog2(OUTST_DEPTH):0]   outstanding,
    output logic                           err_orphan_beat
);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t       state;
    logic [1:0]   rr_ptr;
    logic [1:0]   win_port;
    logic [1:0]   pick;
    logic [ADR_W-1:0] pick_adr;
    logic [LEN_W-1:0] pick_len;

    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    outst_entry_t push_entry;
    outst_entry_t head;
    logic [LEN_W-1:0] beat_cnt;
    logic         beat;

    always_comb begin
        pick     = rr_pick(req_valid, rr_ptr);
        pick_adr = req_base_adr[pick*ADR_W +: ADR_W];
        pick_len = req_length[pick*LEN_W +: LEN_W];
    end

    assign push              = (state == ISSUE) && ddr_cmd_ready;
    assign push_entry.owner  = win_port;
    assign push_entry.length = OUTST_LEN_W'(ddr_cmd_length);

    // While a grant pulse is out the requester has not yet dropped req_valid, so
    // arbitration skips that cycle to avoid re-latching the same request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= PORT_WEIGHTS;
            win_port         <= PORT_WEIGHTS;
            req_grant        <= '0;
            ddr_cmd_valid    <= 1'b0;
            ddr_cmd_base_adr <= '0;
            ddr_cmd_length   <= '0;
        end else begin
            req_grant <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid && !fifo_full && req_grant == '0) begin
                        if (pick_len == '0) begin
                            req_grant <= port_onehot(pick);
                            rr_ptr    <= next_port(pick);
                        end else begin
                            win_port         <= pick;
                            ddr_cmd_base_adr <= pick_adr;
                            ddr_cmd_length   <= pick_len;
                            ddr_cmd_valid    <= 1'b1;
                            state            <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (ddr_cmd_ready) begin
                        req_grant     <= port_onehot(win_port);
                        rr_ptr        <= next_port(win_port);
                        ddr_cmd_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ddr_outst_fifo #(
        .WIDTH ($bits(outst_entry_t)),
        .DEPTH (OUTST_DEPTH)
    ) u_outst_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (outstanding),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign beat           = ddr_rd_data_valid && !fifo_empty;
    assign rd_route_valid = beat ? port_onehot(head.owner) : 3'b000;
    assign rd_last        = beat && (beat_cnt == LEN_W'(head.length) - LEN_W'(1));
    assign pop            = rd_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt        <= '0;
            err_orphan_beat <= 1'b0;
        end else begin
            if (rd_last)   beat_cnt <= '0;
            else if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (ddr_rd_data_valid && fifo_empty) err_orphan_beat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_rd_cmd_arbiter.sv
// tb/tb_ddr_rd_cmd_arbiter.sv - scoreboard bench for ddr_rd_cmd_arbiter
module tb_ddr_rd_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [95:0] req_base_adr = '0;
    logic [47:0] req_length = '0;
    logic [2:0]  req_grant;
    logic        ddr_cmd_ready = 1'b0;
    logic        ddr_cmd_valid;
    logic [31:0] ddr_cmd_base_adr;
    logic [15:0] ddr_cmd_length;
    logic        ddr_rd_data_valid = 1'b0;
    logic [2:0]  rd_route_valid;
    logic        rd_last;
    logic [2:0]  outstanding;
    logic        err_orphan_beat;

    typedef struct { int port; logic [31:0] adr; logic [15:0] len; } cmd_t;
    typedef struct { int owner; int len; } outst_t;

    cmd_t       exp_cmd_q[$];
    logic [2:0] exp_grant_q[$];
    outst_t     model_q[$];
    int         m_cnt = 0;
    logic       exp_orphan = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    ddr_rd_cmd_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_base_adr      (req_base_adr),
        .req_length        (req_length),
        .req_grant         (req_grant),
        .ddr_cmd_ready     (ddr_cmd_ready),
        .ddr_cmd_valid     (ddr_cmd_valid),
        .ddr_cmd_base_adr  (ddr_cmd_base_adr),
        .ddr_cmd_length    (ddr_cmd_length),
        .ddr_rd_data_valid (ddr_rd_data_valid),
        .rd_route_valid    (rd_route_valid),
        .rd_last           (rd_last),
        .outstanding       (outstanding),
        .err_orphan_beat   (err_orphan_beat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: beats are scored against the pre-edge queue, then any accept is pushed.
    always @(negedge clk) begin
        if (!reset) begin
            logic [2:0] exp_route;
            logic       exp_last;
            cmd_t       c;
            check("outstanding", outstanding, model_q.size());
            check("orphan_flag", err_orphan_beat, exp_orphan);
            exp_route = 3'b000;
            exp_last  = 1'b0;
            if (ddr_rd_data_valid) begin
                if (model_q.size() == 0) begin
                    exp_orphan = 1'b1;
                end else begin
                    exp_route = 3'b001 << model_q[0].owner;
                    exp_last  = (m_cnt == model_q[0].len - 1);
                    if (exp_last) begin
                        void'(model_q.pop_front());
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            check("route", rd_route_valid, exp_route);
            check("rd_last", rd_last, exp_last);
            if (req_grant != 3'b000) begin
                if (exp_grant_q.size() == 0) check("grant_unexpected", req_grant, 3'b000);
                else check("grant", req_grant, exp_grant_q.pop_front());
            end
            if (ddr_cmd_valid && ddr_cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", exp_cmd_q.size(), 1);
                end else begin
                    c = exp_cmd_q.pop_front();
                    check("cmd_adr", ddr_cmd_base_adr, c.adr);
                    check("cmd_len", ddr_cmd_length, c.len);
                    model_q.push_back('{c.port, int'(c.len)});
                    exp_grant_q.push_back(3'b001 << c.port);
                end
            end
        end
    end

    task automatic push_cmd(input int p, input logic [31:0] adr, input logic [15:0] len);
        exp_cmd_q.push_back('{p, adr, len});
    endtask

    task automatic request(input int p, input logic [31:0] adr, input logic [15:0] len);
        int n;
        req_base_adr[p*32 +: 32] = adr;
        req_length[p*16 +: 16]   = len;
        req_valid[p]             = 1'b1;
        n = 0;
        while (!req_grant[p] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_grant[p]) check("grant_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic send_beats(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ddr_rd_data_valid = 1'b1;
        end
        @(posedge clk); #1;
        ddr_rd_data_valid = 1'b0;
    endtask

    task automatic wait_cmds_left(input int left, input int budget);
        int n = 0;
        while (exp_cmd_q.size() > left && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cmd_wait_timeout", exp_cmd_q.size(), left);
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        reset             = 1'b1;
        req_valid         = '0;
        ddr_cmd_ready     = 1'b0;
        ddr_rd_data_valid = 1'b0;
        #1;
        check("rst_cmd_valid", ddr_cmd_valid, 0);
        check("rst_cmd_adr", ddr_cmd_base_adr, 0);
        check("rst_cmd_len", ddr_cmd_length, 0);
        check("rst_grant", req_grant, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_orphan", err_orphan_beat, 0);
        check("rst_route", rd_route_valid, 0);
        check("rst_last", rd_last, 0);
        exp_cmd_q.delete();
        exp_grant_q.delete();
        model_q.delete();
        m_cnt      = 0;
        exp_orphan = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        apply_reset();

        // Single port-0 command, 4 beats.
        ddr_cmd_ready = 1'b1;
        @(posedge clk); #1;
        push_cmd(0, 32'h100, 16'd4);
        req_base_adr[31:0] = 32'h100;
        req_length[15:0]   = 16'd4;
        req_valid[0]       = 1'b1;
        @(negedge clk);
        check("t1_cmd_valid_pre", ddr_cmd_valid, 0);
        @(negedge clk);
        check("t1_cmd_valid", ddr_cmd_valid, 1);
        @(negedge clk);
        check("t1_grant", req_grant, 3'b001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        send_beats(4);
        @(negedge clk);
        check("t1_outstanding_end", outstanding, 0);

        // Three simultaneous requests with a toggling ready.
        apply_reset();
        push_cmd(0, 32'h2000, 16'd2);
        push_cmd(1, 32'h3000, 16'd2);
        push_cmd(2, 32'h4000, 16'd2);
        fork
            request(0, 32'h2000, 16'd2);
            request(1, 32'h3000, 16'd2);
            request(2, 32'h4000, 16'd2);
            begin
                for (int i = 0; i < 200 && exp_cmd_q.size() != 0; i++) begin
                    @(posedge clk); #1;
                    ddr_cmd_ready = ~ddr_cmd_ready;
                end
            end
        join
        ddr_cmd_ready = 1'b1;
        send_beats(6);

        // Zero-length request: grant only, no DDR command.
        exp_grant_q.push_back(3'b100);
        request(2, 32'h5000, 16'd0);
        repeat (3) @(posedge clk);
        check("t2_zero_grant_left", exp_grant_q.size(), 0);

        // Full FIFO stalls the fifth request until a pop.
        for (int k = 0; k < 5; k++) push_cmd(1, 32'h1000 + k * 32'h200, 16'd8);
        fork
            for (int k = 0; k < 5; k++) request(1, 32'h1000 + k * 32'h200, 16'd8);
            begin
                wait_cmds_left(1, 200);
                repeat (5) @(negedge clk);
                check("t3_outstanding_full", outstanding, 4);
                check("t3_cmd_stalled", ddr_cmd_valid, 0);
                send_beats(7);
                repeat (3) @(negedge clk);
                check("t3_still_stalled", ddr_cmd_valid, 0);
                send_beats(1);
                wait_cmds_left(0, 50);
                send_beats(32);
            end
        join
        @(negedge clk);
        check("t3_drained", outstanding, 0);

        // Orphan beat is flagged and sticks until reset.
        send_beats(1);
        repeat (4) @(negedge clk);
        check("t4_orphan_sticky", err_orphan_beat, 1);
        apply_reset();

        // Last beat of one command coincides with accept of the next.
        ddr_cmd_ready = 1'b1;
        push_cmd(0, 32'h6000, 16'd2);
        request(0, 32'h6000, 16'd2);
        ddr_cmd_ready = 1'b0;
        push_cmd(1, 32'h7000, 16'd3);
        fork
            request(1, 32'h7000, 16'd3);
            begin
                for (int i = 0; i < 50 && !ddr_cmd_valid; i++) @(negedge clk);
                check("t5_cmd_pending", ddr_cmd_valid, 1);
                @(posedge clk); #1;
                ddr_rd_data_valid = 1'b1;
                @(posedge clk); #1;
                ddr_cmd_ready = 1'b1;
                @(negedge clk);
                check("t5_coincide_last", rd_last, 1);
                @(posedge clk); #1;
                ddr_rd_data_valid = 1'b0;
                ddr_cmd_ready     = 1'b0;
                @(negedge clk);
                check("t5_outstanding_same", outstanding, 1);
                @(posedge clk); #1;
                ddr_rd_data_valid = 1'b1;
                @(negedge clk);
                check("t5_new_owner", rd_route_valid, 3'b010);
                @(posedge clk); #1;
                ddr_rd_data_valid = 1'b0;
            end
        join
        send_beats(2);

        // Reset mid-burst, then port 0 has priority again.
        ddr_cmd_ready = 1'b1;
        push_cmd(2, 32'h8000, 16'd4);
        request(2, 32'h8000, 16'd4);
        send_beats(2);
        apply_reset();
        ddr_cmd_ready = 1'b1;
        push_cmd(0, 32'h9000, 16'd2);
        push_cmd(1, 32'hA000, 16'd1);
        push_cmd(2, 32'hB000, 16'd3);
        fork
            request(2, 32'hB000, 16'd3);
            request(1, 32'hA000, 16'd1);
            request(0, 32'h9000, 16'd2);
        join
        send_beats(6);
        @(negedge clk);
        check("t6_drained", outstanding, 0);
        check("t6_no_orphan", err_orphan_beat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
